// File: rtl/program_counter_pkg.sv
// Shared types and widths for the fetch-stage program counter.
// The return stack is compiled in only when PC_RETURN_STACK_EN is defined.
package program_counter_pkg;

    localparam int unsigned PC_W = 10;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } pc_state_e;

    // One cycle's worth of control requests seen by the counter.
    typedef struct packed {
        logic            stall;
        logic            halt;
        logic            resume;
        logic            jump;
        logic            call;
        logic            ret;
        logic [PC_W-1:0] target;
    } pc_req_t;

endpackage

// File: rtl/program_counter_incrementer.sv
// Ripple incrementer: a chain of half-adder cells with the first carry-in tied to 1,
// the up-counting counterpart of the ten-bit decrementer.
module program_counter_incrementer
    import program_counter_pkg::*;
(
    input  logic [PC_W-1:0] a,
    output logic [PC_W-1:0] s,
    output logic            o
);

    logic [PC_W:0] c;

    assign c[0] = 1'b1;

    for (genvar i = 0; i < PC_W; i++) begin : g_ha
        assign s[i]   = a[i] ^ c[i];
        assign c[i+1] = a[i] & c[i];
    end

    assign o = c[PC_W];

endmodule

// File: rtl/program_counter.sv
// 10-bit fetch program counter with jump, stall, halt/resume and a registered wrap pulse.
// Defining PC_RETURN_STACK_EN adds a RAS_DEPTH-entry call/return stack.
module program_counter
    import program_counter_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_ADDR = 10'h000,
    parameter int unsigned     RAS_DEPTH  = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            halt,
    input  logic            resume,
    input  logic            jump,
    input  logic            call,
    input  logic            ret,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            pc_valid,
    output logic            wrap,
    output logic            ras_err
);

    if ((RAS_DEPTH < 2) || (RAS_DEPTH > 8) || ((RAS_DEPTH & (RAS_DEPTH - 1)) != 0)) begin : g_bad_ras_depth
        $error("RAS_DEPTH must be a power of 2 in the range 2..8");
    end

    pc_state_e       state;
    pc_state_e       state_nxt;
    pc_req_t         req;
    logic [PC_W-1:0] pc_inc;
    logic            inc_carry;
    logic [PC_W-1:0] pc_nxt;
    logic            wrap_nxt;
    logic            err_nxt;

    assign req = '{stall: stall, halt: halt, resume: resume, jump: jump,
                   call: call, ret: ret, target: target};

    program_counter_incrementer u_inc (
        .a (pc),
        .s (pc_inc),
        .o (inc_carry)
    );

`ifdef PC_RETURN_STACK_EN
    localparam int unsigned SP_W   = $clog2(RAS_DEPTH);
    localparam logic [SP_W:0] SP_ONE  = (SP_W+1)'(1);
    localparam logic [SP_W:0] SP_FULL = (SP_W+1)'(RAS_DEPTH);

    logic [PC_W-1:0] ras_mem [RAS_DEPTH];
    logic [SP_W:0]   sp;
    logic [SP_W:0]   sp_nxt;
    logic            push;
    logic            ras_full;
    logic            ras_empty;
    logic [PC_W-1:0] ras_top;

    assign ras_full  = (sp == SP_FULL);
    assign ras_empty = (sp == '0);
    assign ras_top   = ras_mem[SP_W'(sp - SP_ONE)];
`else
    logic unused_ret;
    assign unused_ret = req.ret;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a stall freezes the FSM in every state.
    always_comb begin
        state_nxt = state;
        if (!req.stall) begin
            case (state)
                ST_BOOT: state_nxt = ST_RUN;
                ST_RUN:  if (req.halt)   state_nxt = ST_HALT;
                ST_HALT: if (req.resume) state_nxt = ST_RUN;
                default: state_nxt = ST_BOOT;
            endcase
        end
    end

    // Next pc, pulses and stack moves; only RUN without stall changes anything.
    always_comb begin
        pc_nxt   = pc;
        wrap_nxt = 1'b0;
        err_nxt  = 1'b0;
`ifdef PC_RETURN_STACK_EN
        sp_nxt   = sp;
        push     = 1'b0;
`endif
        if ((state == ST_RUN) && !req.stall) begin
`ifdef PC_RETURN_STACK_EN
            if (req.ret) begin
                if (!ras_empty) begin
                    pc_nxt = ras_top;
                    sp_nxt = sp - SP_ONE;
                end else begin
                    pc_nxt   = pc_inc;
                    wrap_nxt = inc_carry;
                    err_nxt  = 1'b1;
                end
            end else if (req.call) begin
                pc_nxt = req.target;
                if (ras_full) begin
                    err_nxt = 1'b1;
                end else begin
                    push   = 1'b1;
                    sp_nxt = sp + SP_ONE;
                end
            end else if (req.jump) begin
                pc_nxt = req.target;
            end else begin
                pc_nxt   = pc_inc;
                wrap_nxt = inc_carry;
            end
`else
            if (req.call || req.jump) begin
                pc_nxt = req.target;
            end else begin
                pc_nxt   = pc_inc;
                wrap_nxt = inc_carry;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RESET_ADDR;
            pc_valid <= 1'b0;
            wrap     <= 1'b0;
            ras_err  <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            pc_valid <= (state_nxt == ST_RUN);
            wrap     <= wrap_nxt;
            ras_err  <= err_nxt;
        end
    end

`ifdef PC_RETURN_STACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= '0;
        end else begin
            sp <= sp_nxt;
        end
    end

    // Stack contents need no reset: the pointer alone defines what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            ras_mem[SP_W'(sp)] <= pc_inc;
        end
    end
`endif

endmodule

// File: tb/tb_program_counter.sv
// Bench for program_counter (RESET_ADDR=10'h010, RAS_DEPTH=4): a directed vector table,
// hand sequences for stack/reset corners, and randomized traffic against a queue-based model.
module tb_program_counter;

    localparam logic [9:0] RST_PC = 10'h010;
    localparam int DEPTH = 4;
`ifdef PC_RETURN_STACK_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       stall, halt, resume, jump, call, ret;
    logic [9:0] target;
    logic [9:0] pc;
    logic       pc_valid, wrap, ras_err;

    program_counter #(.RESET_ADDR(RST_PC), .RAS_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .halt(halt), .resume(resume),
        .jump(jump), .call(call), .ret(ret), .target(target),
        .pc(pc), .pc_valid(pc_valid), .wrap(wrap), .ras_err(ras_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: mode 0=boot, 1=run, 2=halt; the stack is a plain queue.
    int m_pc;
    int m_mode;
    bit m_valid, m_wrap, m_err;
    int m_stack[$];

    task automatic model_reset();
        m_pc = int'(RST_PC);
        m_mode = 0;
        m_valid = 0; m_wrap = 0; m_err = 0;
        m_stack.delete();
    endtask

    task automatic model_inc();
        m_wrap = (m_pc == 1023);
        m_pc = (m_pc + 1) % 1024;
    endtask

    task automatic model_step(input bit st, input bit h, input bit r, input bit j,
                              input bit c, input bit rt, input int t);
        m_wrap = 0;
        m_err = 0;
        if (!st) begin
            if (m_mode == 0) begin
                m_mode = 1;
            end else if (m_mode == 1) begin
                if (RAS_EN && rt) begin
                    if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                    else begin m_err = 1; model_inc(); end
                end else if (c) begin
                    if (RAS_EN) begin
                        if (m_stack.size() < DEPTH) m_stack.push_back((m_pc + 1) % 1024);
                        else m_err = 1;
                    end
                    m_pc = t;
                end else if (j) begin
                    m_pc = t;
                end else begin
                    model_inc();
                end
                if (h) m_mode = 2;
            end else if (r) begin
                m_mode = 1;
            end
        end
        m_valid = (m_mode == 1);
    endtask

    task automatic drive(input bit st, input bit h, input bit r, input bit j,
                         input bit c, input bit rt, input logic [9:0] t);
        stall = st; halt = h; resume = r; jump = j; call = c; ret = rt; target = t;
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_pc"},    32'(pc),       32'(m_pc));
        check({tag, "_valid"}, 32'(pc_valid), 32'(m_valid));
        check({tag, "_wrap"},  32'(wrap),     32'(m_wrap));
        check({tag, "_err"},   32'(ras_err),  32'(m_err));
    endtask

    // Drive one cycle, advance the model, compare after the edge.
    task automatic apply(input string tag, input bit st, input bit h, input bit r, input bit j,
                         input bit c, input bit rt, input logic [9:0] t);
        drive(st, h, r, j, c, rt, t);
        @(posedge clk);
        #1;
        model_step(st, h, r, j, c, rt, int'(t));
        compare_model(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 10'h000);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_model(tag);
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         st, h, r, j, c, rt;
        logic [9:0] t;
        logic [9:0] exp_pc;
        bit         exp_valid, exp_wrap, exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input bit st, input bit h, input bit r, input bit j, input bit c,
                           input bit rt, input logic [9:0] t, input logic [9:0] e_pc,
                           input bit e_v, input bit e_w, input bit e_e);
        vec_t v;
        v.st = st; v.h = h; v.r = r; v.j = j; v.c = c; v.rt = rt; v.t = t;
        v.exp_pc = e_pc; v.exp_valid = e_v; v.exp_wrap = e_w; v.exp_err = e_e;
        vecs.push_back(v);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 10'h000);

        //        st h r j c rt target   pc     v w e
        add_vec(0,0,0,0,0,0, 10'h000, 10'h010, 1,0,0);
        add_vec(0,0,0,0,0,0, 10'h000, 10'h011, 1,0,0);
        add_vec(0,0,0,0,0,0, 10'h000, 10'h012, 1,0,0);
        add_vec(0,0,0,1,0,0, 10'h3FE, 10'h3FE, 1,0,0);
        add_vec(0,0,0,0,0,0, 10'h000, 10'h3FF, 1,0,0);
        add_vec(0,0,0,0,0,0, 10'h000, 10'h000, 1,1,0);
        add_vec(0,0,0,0,0,0, 10'h000, 10'h001, 1,0,0);
        add_vec(1,0,0,1,0,0, 10'h2A5, 10'h001, 1,0,0);
        add_vec(0,0,0,1,0,0, 10'h2A5, 10'h2A5, 1,0,0);
        add_vec(0,0,0,1,0,0, 10'h000, 10'h000, 1,0,0);
        add_vec(0,0,0,1,0,0, 10'h04F, 10'h04F, 1,0,0);
        add_vec(0,0,0,0,0,0, 10'h000, 10'h050, 1,0,0);
        add_vec(0,1,0,0,0,0, 10'h000, 10'h051, 0,0,0);
        add_vec(0,1,0,0,0,0, 10'h000, 10'h051, 0,0,0);
        add_vec(0,0,0,1,0,0, 10'h123, 10'h051, 0,0,0);
        add_vec(0,0,0,0,1,0, 10'h200, 10'h051, 0,0,0);
        add_vec(0,0,0,0,0,1, 10'h000, 10'h051, 0,0,0);
        add_vec(0,0,0,0,0,0, 10'h000, 10'h051, 0,0,0);
        add_vec(0,0,1,0,0,0, 10'h000, 10'h051, 1,0,0);
        add_vec(0,0,0,0,0,0, 10'h000, 10'h052, 1,0,0);
        add_vec(1,1,0,0,0,0, 10'h000, 10'h052, 1,0,0);
        add_vec(0,1,1,0,0,0, 10'h000, 10'h053, 0,0,0);
        add_vec(0,1,1,0,0,0, 10'h000, 10'h053, 1,0,0);
        add_vec(0,0,0,0,1,0, 10'h100, 10'h100, 1,0,0);
`ifdef PC_RETURN_STACK_EN
        add_vec(0,0,0,0,0,1, 10'h000, 10'h054, 1,0,0);
        add_vec(0,0,0,0,0,1, 10'h000, 10'h055, 1,0,1);
`else
        add_vec(0,0,0,0,0,1, 10'h000, 10'h101, 1,0,0);
        add_vec(0,0,0,0,0,1, 10'h000, 10'h102, 1,0,0);
`endif
        add_vec(1,0,0,0,0,1, 10'h000, pc_after_ret2(), 1,0,0);

        do_reset("reset0");
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].h, vecs[i].r, vecs[i].j, vecs[i].c, vecs[i].rt, vecs[i].t);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pc", i),    32'(pc),       32'(vecs[i].exp_pc));
            check($sformatf("vec%0d_valid", i), 32'(pc_valid), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_wrap", i),  32'(wrap),     32'(vecs[i].exp_wrap));
            check($sformatf("vec%0d_err", i),   32'(ras_err),  32'(vecs[i].exp_err));
        end

        // Call/return round trip, then nest past the stack depth.
        do_reset("reset1");
        apply("boot", 0,0,0,0,0,0, 10'h000);
        apply("jmp020", 0,0,0,1,0,0, 10'h020);
        apply("call100", 0,0,0,0,1,0, 10'h100);
        check("call100_target", 32'(pc), 32'h100);
        apply("ret", 0,0,0,0,0,1, 10'h000);
        check("ret_addr", 32'(pc), RAS_EN ? 32'h021 : 32'h101);
        for (int i = 0; i < 5; i++) begin
            apply($sformatf("nest%0d", i), 0,0,0,0,1,0, 10'(10'h200 + i));
            check($sformatf("nest%0d_raserr", i), 32'(ras_err), 32'(RAS_EN && (i == 4)));
        end

        // Reset lands asynchronously in the middle of a call sequence.
        apply("call300", 0,0,0,0,1,0, 10'h300);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("async_rst_pc", 32'(pc), 32'(RST_PC));
        check("async_rst_valid", 32'(pc_valid), 32'h0);
        drive(0, 0, 0, 0, 0, 0, 10'h000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply("boot2", 0,0,0,0,0,0, 10'h000);
        apply("ret_after_rst", 0,0,0,0,0,1, 10'h000);
        check("ret_after_rst_raserr", 32'(ras_err), 32'(RAS_EN));
        check("ret_after_rst_pc", 32'(pc), 32'h011);

        // Randomized traffic against the model, with one reset partway through.
        do_reset("reset2");
        for (int i = 0; i < 600; i++) begin
            bit st, h, r, j, c, rt;
            logic [9:0] t;
            if (i == 300) do_reset("reset3");
            st = ($urandom_range(0, 99) < 12);
            h  = ($urandom_range(0, 99) < 5);
            r  = ($urandom_range(0, 99) < 30);
            j  = ($urandom_range(0, 99) < 10);
            c  = ($urandom_range(0, 99) < 12);
            rt = ($urandom_range(0, 99) < 12);
            t  = ($urandom_range(0, 7) == 0) ? 10'h3FE : 10'($urandom);
            apply($sformatf("rnd%0d", i), st, h, r, j, c, rt, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    function automatic logic [9:0] pc_after_ret2();
        return RAS_EN ? 10'h055 : 10'h102;
    endfunction

endmodule
